// File: rtl/mode_mod_counter_pkg.sv
// Shared definitions for the selectable-modulus counter family.
package counter_pkg;

  // Upper bounds for the generic table lookup helper.
  localparam int unsigned TABLE_BITS_MAX = 256;
  localparam int unsigned WIDTH_MAX      = 32;

  // Entry i (LSB-first) is the maximum count for mode i: 9, 11, 13, 15.
  localparam logic [15:0] DEFAULT_MAX_TABLE = {4'd15, 4'd13, 4'd11, 4'd9};

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  // Returns the table entry for idx; an out-of-range idx selects entry 0.
  function automatic logic [WIDTH_MAX-1:0] mode_max(
    input logic [TABLE_BITS_MAX-1:0] tbl,
    input int unsigned               idx,
    input int unsigned               width = 4,
    input int unsigned               modes = 4
  );
    logic [TABLE_BITS_MAX-1:0] shifted;
    logic [WIDTH_MAX-1:0]      res;
    int unsigned               sel;
    sel     = (idx < modes) ? idx : 0;
    shifted = tbl >> (sel * width);
    res     = '0;
    for (int unsigned b = 0; b < WIDTH_MAX; b++) begin
      if (b < width) res[b] = shifted[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/mode_mod_counter_max_lut.sv
// Combinational lookup of a mode's maximum count from the packed table.
module max_lut
  import counter_pkg::*;
#(
  parameter int unsigned              WIDTH     = 4,
  parameter int unsigned              MODES     = 4,
  parameter int unsigned              MODE_W    = $clog2(MODES),
  parameter logic [MODES*WIDTH-1:0]   MAX_TABLE = DEFAULT_MAX_TABLE
) (
  input  logic [MODE_W-1:0] idx,
  output logic [WIDTH-1:0]  max_val
);

  // Table entry select; invalid indices fall back to entry 0.
  always_comb begin
    max_val = WIDTH'(mode_max(TABLE_BITS_MAX'(MAX_TABLE), 32'(idx), WIDTH, MODES));
  end

endmodule

// File: rtl/mode_mod_counter.sv
// Up/down counter whose modulus comes from a per-mode table. A requested
// mode change is deferred until the next wrap, load or reset so the count
// never exceeds the maximum of the mode currently in force.
module mode_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned              WIDTH     = 4,
  parameter int unsigned              MODES     = 4,
  parameter int unsigned              MODE_W    = $clog2(MODES),
  parameter logic [MODES*WIDTH-1:0]   MAX_TABLE = DEFAULT_MAX_TABLE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              up_dn,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [MODE_W-1:0] mode,
  output logic [WIDTH-1:0]  out,
  output logic [MODE_W-1:0] active_mode,
  output logic              wrap,
  output logic              tc
);

  logic [WIDTH-1:0]  out_q, out_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              wrap_q, wrap_d;
  logic [WIDTH-1:0]  cur_max;   // maximum of the active mode
  logic [WIDTH-1:0]  new_max;   // maximum of the requested mode
  logic [MODE_W-1:0] sel_mode;  // requested mode, invalid values folded to 0

  max_lut #(
    .WIDTH    (WIDTH),
    .MODES    (MODES),
    .MODE_W   (MODE_W),
    .MAX_TABLE(MAX_TABLE)
  ) u_cur_lut (
    .idx    (mode_q),
    .max_val(cur_max)
  );

  max_lut #(
    .WIDTH    (WIDTH),
    .MODES    (MODES),
    .MODE_W   (MODE_W),
    .MAX_TABLE(MAX_TABLE)
  ) u_new_lut (
    .idx    (mode),
    .max_val(new_max)
  );

  // Fold out-of-range mode requests to mode 0.
  always_comb begin
    sel_mode = ({{(32-MODE_W){1'b0}}, mode} < MODES) ? mode : '0;
  end

  // Next-state: load beats count beats hold; wraps adopt the requested mode.
  always_comb begin
    out_d  = out_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    if (load) begin
      mode_d = sel_mode;
      out_d  = (load_val > new_max) ? new_max : load_val;
    end else if (en) begin
      if (up_dn == UP) begin
        if (out_q == cur_max) begin
          out_d  = '0;
          wrap_d = 1'b1;
          mode_d = sel_mode;
        end else begin
          out_d = out_q + WIDTH'(1);
        end
      end else begin
        if (out_q == '0) begin
          out_d  = new_max;
          wrap_d = 1'b1;
          mode_d = sel_mode;
        end else begin
          out_d = out_q - WIDTH'(1);
        end
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q  <= '0;
      mode_q <= sel_mode;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
    end
  end

  // Terminal count for cascading; deliberately not gated by load.
  always_comb begin
    tc = en & ((up_dn == UP) ? (out_q == cur_max) : (out_q == '0));
  end

  assign out         = out_q;
  assign active_mode = mode_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_mode_mod_counter.sv
// Scoreboard bench: two counters (default table and one with a zero-max
// mode) share randomized and directed stimulus; a behavioural model pushes
// expectations that a separate monitor compares.
module tb_mode_mod_counter;

  logic       clk = 1'b0;
  logic       reset, en, up_dn, load;
  logic [3:0] load_val;
  logic [1:0] mode;
  logic [3:0] out0, out1;
  logic [1:0] am0, am1;
  logic       wrap0, wrap1, tc0, tc1;

  always #5 clk = ~clk;

  mode_mod_counter u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up_dn      (up_dn),
    .load       (load),
    .load_val   (load_val),
    .mode       (mode),
    .out        (out0),
    .active_mode(am0),
    .wrap       (wrap0),
    .tc         (tc0)
  );

  mode_mod_counter #(
    .MAX_TABLE({4'd7, 4'd3, 4'd5, 4'd0})
  ) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up_dn      (up_dn),
    .load       (load),
    .load_val   (load_val),
    .mode       (mode),
    .out        (out1),
    .active_mode(am1),
    .wrap       (wrap1),
    .tc         (tc1)
  );

  typedef struct {
    bit chk_cur;
    int cur_out;
    bit tc;
    bit chk_next;
    int n_out;
    int n_mode;
    bit n_wrap;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks   = 0;
  int failures = 0;

  // Reference model: per-mode maxima and abstract state.
  int  tbl[2][4];
  int  m_out[2];
  int  m_mode[2];
  bit  m_valid = 1'b0;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit u, input bit l,
                      input int lv, input int md);
    exp_t rec;
    int   mx, nmx, nmd;
    @(negedge clk);
    reset    = r;
    en       = e;
    up_dn    = u;
    load     = l;
    load_val = 4'(lv);
    mode     = 2'(md);
    nmd      = (md < 4) ? md : 0;
    for (int d = 0; d < 2; d++) begin
      mx          = tbl[d][m_mode[d]];
      nmx         = tbl[d][nmd];
      rec.chk_cur = m_valid;
      rec.cur_out = m_out[d];
      rec.tc      = e && (u ? (m_out[d] == mx) : (m_out[d] == 0));
      rec.n_wrap  = 1'b0;
      if (!r) begin
        m_out[d]  = 0;
        m_mode[d] = nmd;
      end else if (!m_valid) begin
        // state undefined until the first reset
      end else if (l) begin
        m_mode[d] = nmd;
        m_out[d]  = (lv < nmx) ? lv : nmx;
      end else if (e && u) begin
        m_out[d] = (m_out[d] + 1) % (mx + 1);
        if (m_out[d] == 0) begin
          rec.n_wrap = 1'b1;
          m_mode[d]  = nmd;
        end
      end else if (e) begin
        if (m_out[d] == 0) begin
          m_out[d]   = nmx;
          rec.n_wrap = 1'b1;
          m_mode[d]  = nmd;
        end else begin
          m_out[d] = m_out[d] - 1;
        end
      end
      rec.chk_next = m_valid || !r;
      rec.n_out    = m_out[d];
      rec.n_mode   = m_mode[d];
      if (d == 0) q0.push_back(rec);
      else        q1.push_back(rec);
    end
    if (!r) m_valid = 1'b1;
  endtask

  // Monitor: combinational outputs before the edge, registered ones after.
  initial begin
    exp_t e0, e1;
    forever begin
      @(negedge clk);
      #2;
      if (q0.size() > 0 && q1.size() > 0) begin
        e0 = q0[0];
        e1 = q1[0];
        if (e0.chk_cur) begin
          cmp("tc0", int'(tc0), int'(e0.tc));
          cmp("hold_out0", int'(out0), e0.cur_out);
        end
        if (e1.chk_cur) begin
          cmp("tc1", int'(tc1), int'(e1.tc));
          cmp("hold_out1", int'(out1), e1.cur_out);
        end
      end
      @(posedge clk);
      #1;
      if (q0.size() > 0 && q1.size() > 0) begin
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        if (e0.chk_next) begin
          cmp("out0", int'(out0), e0.n_out);
          cmp("mode0", int'(am0), e0.n_mode);
          cmp("wrap0", int'(wrap0), int'(e0.n_wrap));
        end
        if (e1.chk_next) begin
          cmp("out1", int'(out1), e1.n_out);
          cmp("mode1", int'(am1), e1.n_mode);
          cmp("wrap1", int'(wrap1), int'(e1.n_wrap));
        end
      end
    end
  end

  initial begin
    tbl[0] = '{9, 11, 13, 15};
    tbl[1] = '{0, 5, 3, 7};
    m_out  = '{0, 0};
    m_mode = '{0, 0};
    reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0; mode = '0;

    // Reset into mode 2 and count through a full cycle.
    step(0, 0, 1, 0, 0, 2);
    for (int i = 0; i < 16; i++) step(1, 1, 1, 0, 0, 2);

    // Deferred mode switch: count to 5 in mode 0, request mode 3.
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 22; i++) step(1, 1, 1, 0, 0, 3);

    // Down-count wrap adopting a new mode.
    step(0, 0, 1, 0, 0, 1);
    step(1, 1, 0, 0, 0, 2);
    step(1, 1, 0, 0, 0, 2);

    // Up at max then down: no wrap.
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);

    // Load clamp and priority over counting.
    step(0, 0, 1, 0, 0, 0);
    step(1, 1, 1, 1, 14, 0);
    step(1, 1, 1, 1, 3, 3);

    // Reset mid-count, with load at the same edge.
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0, 3);
    step(0, 1, 1, 1, 5, 3);

    // Hold for several edges, then zero-modulus counting on dut1 mode 0.
    step(1, 1, 1, 1, 6, 1);
    for (int i = 0; i < 5; i++) step(1, 0, i[0], 0, 0, 2);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, i[1], 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'(mode));
    end

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && q0.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    cmp("queue_drained", q0.size() + q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
